// File: rtl/ysyx_24100006_fencei_ctrl_pkg.sv
// Shared definitions for the fence.i sequencer: FSM state encodings and
// default counter widths.
package ysyx_24100006_fencei_ctrl_pkg;

  localparam int TMO_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int FS_W      = 3;

  localparam logic [FS_W-1:0] FS_IDLE    = 3'd0;
  localparam logic [FS_W-1:0] FS_DRAIN   = 3'd1;
  localparam logic [FS_W-1:0] FS_FLUSH   = 3'd2;
  localparam logic [FS_W-1:0] FS_WAIT    = 3'd3;
  localparam logic [FS_W-1:0] FS_RELEASE = 3'd4;

endpackage

// File: rtl/ysyx_24100006_fencei_ctrl_if.sv
// EXE-stage handshake bundle: the ID_EXE->EXEU (upstream) and EXEU->EXE_MEM
// (downstream) valid/ready pairs plus the instruction info the sequencer needs.
//
// Handshake rule (both pairs): a transfer happens on a posedge where valid and
// ready are both 1. Once valid is raised it stays high, and its payload
// (is_fence_i, pc_add_4) stays stable, until that transfer. ready may change
// freely and may depend combinationally on valid.
interface ysyx_24100006_fencei_ctrl_if;

  logic        exe_out_valid;
  logic        exe_out_ready;
  logic        exe_in_valid;
  logic        exe_in_ready;
  logic        is_fence_i;
  logic [31:0] pc_add_4;

  // Pipeline side: presents the instruction, consumes the gated handshake.
  modport master (
    output exe_out_valid,
    output is_fence_i,
    output pc_add_4,
    output exe_in_ready,
    input  exe_out_ready,
    input  exe_in_valid
  );

  // Sequencer side.
  modport slave (
    input  exe_out_valid,
    input  is_fence_i,
    input  pc_add_4,
    input  exe_in_ready,
    output exe_out_ready,
    output exe_in_valid
  );

endinterface

// File: rtl/ysyx_24100006_fencei_ctrl.sv
// fence.i sequencer at EXE: holds the fence.i in EXE while stores drain and
// the icache flushes, then releases it downstream and redirects fetch to pc+4.
module ysyx_24100006_fencei_ctrl
  import ysyx_24100006_fencei_ctrl_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  ysyx_24100006_fencei_ctrl_if.slave exe,
  input  logic                 mem_store_pending,
  input  logic                 icache_flush_done,
  output logic                 icache_flush_req,
  output logic                 fence_redirect_valid,
  output logic [31:0]          fence_redirect_pc,
  output logic                 fence_busy,
  output logic                 fence_timeout,
  output logic [CNT_W-1:0]     fence_cnt,
  output logic [FS_W-1:0]      fsm_state
);

  localparam logic [TMO_W-1:0] TMO_MAX = '1;
  localparam logic [TMO_W-1:0] TMO_PRE = TMO_MAX - 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [FS_W-1:0]  state;
  logic [FS_W-1:0]  state_nxt;
  logic [31:0]      pc_q;
  logic [TMO_W-1:0] tmo;
  logic             fire_f;
  logic             xfer_f;

  assign fire_f = exe.exe_out_valid & exe.is_fence_i;
  assign xfer_f = (state == FS_RELEASE) & exe.exe_in_ready;

  always_comb begin
    state_nxt         = state;
    exe.exe_in_valid  = 1'b0;
    exe.exe_out_ready = 1'b0;
    case (state)
      FS_IDLE: begin
        if (fire_f) begin
          state_nxt = FS_DRAIN;
        end else begin
          exe.exe_in_valid  = exe.exe_out_valid;
          exe.exe_out_ready = exe.exe_in_ready;
        end
      end
      FS_DRAIN: begin
        if (!mem_store_pending) state_nxt = FS_FLUSH;
      end
      FS_FLUSH: begin
        state_nxt = FS_WAIT;
      end
      FS_WAIT: begin
        if (icache_flush_done) state_nxt = FS_RELEASE;
      end
      FS_RELEASE: begin
        exe.exe_in_valid  = 1'b1;
        exe.exe_out_ready = exe.exe_in_ready;
        if (exe.exe_in_ready) state_nxt = FS_IDLE;
      end
      default: state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FS_IDLE;
      pc_q          <= '0;
      tmo           <= '0;
      fence_timeout <= 1'b0;
      fence_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == FS_IDLE && fire_f) pc_q <= exe.pc_add_4;
      if (state == FS_FLUSH) tmo <= '0;
      // Timeout flag rises together with the counter reaching all-ones,
      // so it is visible right after the (2**TMO_W-1)-th waiting cycle.
      if (state == FS_WAIT && !icache_flush_done) begin
        if (tmo != TMO_MAX) tmo <= tmo + 1'b1;
        if (tmo >= TMO_PRE) fence_timeout <= 1'b1;
      end
      if (xfer_f && fence_cnt != CNT_MAX) fence_cnt <= fence_cnt + 1'b1;
    end
  end

  // Both pulses decode the registered state, so they can never overlap.
  assign icache_flush_req     = (state == FS_FLUSH);
  assign fence_redirect_valid = xfer_f;
  assign fence_redirect_pc    = pc_q;
  assign fence_busy           = (state != FS_IDLE);
  assign fsm_state            = state;

endmodule

// File: tb/tb_ysyx_24100006_fencei_ctrl.sv
// Self-checking bench for the fence.i sequencer: directed scenarios plus
// randomized fences checked against a timeline model derived from the rules.
module tb_ysyx_24100006_fencei_ctrl;
  import ysyx_24100006_fencei_ctrl_pkg::*;

  localparam int TMO_W = 4;
  localparam int CNT_W = 3;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mem_store_pending;
  logic              icache_flush_done;
  logic              icache_flush_req;
  logic              fence_redirect_valid;
  logic [31:0]       fence_redirect_pc;
  logic              fence_busy;
  logic              fence_timeout;
  logic [CNT_W-1:0]  fence_cnt;
  logic [FS_W-1:0]   fsm_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_cnt  = 0;
  logic [31:0] exp_q[$];

  ysyx_24100006_fencei_ctrl_if exe ();

  ysyx_24100006_fencei_ctrl #(.TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .exe                  (exe.slave),
    .mem_store_pending    (mem_store_pending),
    .icache_flush_done    (icache_flush_done),
    .icache_flush_req     (icache_flush_req),
    .fence_redirect_valid (fence_redirect_valid),
    .fence_redirect_pc    (fence_redirect_pc),
    .fence_busy           (fence_busy),
    .fence_timeout        (fence_timeout),
    .fence_cnt            (fence_cnt),
    .fsm_state            (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    @(negedge clk);
    exe.exe_out_valid = 1'b0;
    exe.is_fence_i    = 1'b0;
    exe.pc_add_4      = '0;
    exe.exe_in_ready  = 1'b0;
    mem_store_pending = 1'b0;
    icache_flush_done = 1'b0;
  endtask

  task automatic drive_fence(input logic [31:0] pc);
    exe.exe_out_valid = 1'b1;
    exe.is_fence_i    = 1'b1;
    exe.pc_add_4      = pc;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_SAT) ? CNT_SAT : v + 1;
  endfunction

  // One full fence.i. Store drain lasts p cycles, flush-done rises d cycles
  // after the req pulse, downstream stalls s cycles in release.
  // Expected timeline relative to the fire cycle (k=0):
  //   req at k=p+2, release starts at p+d+3, transfer/redirect at p+d+3+s.
  task automatic run_fence(input logic [31:0] pc, input int p, input int d,
                           input int s, input string tag);
    int t_req, t_rel, t_x;
    int seen_req, n_req, seen_rdr, gate_err, busy_err;
    logic [31:0] got_pc, want_pc;
    t_req = p + 2;
    t_rel = p + d + 3;
    t_x   = t_rel + s;
    seen_req = -1; n_req = 0; seen_rdr = -1; gate_err = 0; busy_err = 0;
    got_pc = '0;
    exp_q.push_back(pc);
    for (int k = 0; k < t_x + 20; k++) begin
      @(negedge clk);
      drive_fence(pc);
      mem_store_pending = (k >= 1 && k <= p);
      icache_flush_done = (k >= t_req + d);
      exe.exe_in_ready  = (k >= t_x) ? 1'b1 :
                          (k < t_rel) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (icache_flush_req) begin
        n_req++;
        if (seen_req < 0) seen_req = k;
      end
      if (exe.exe_in_valid !== (k >= t_rel) || exe.exe_out_ready !== (k == t_x))
        gate_err++;
      if (fence_busy !== (k != 0)) busy_err++;
      if (fence_redirect_valid === 1'b1) begin
        seen_rdr = k;
        got_pc   = fence_redirect_pc;
        break;
      end
    end
    want_pc = exp_q.pop_front();
    n_checks++;
    if (seen_req !== t_req) begin
      n_fail++;
      $display("FAIL %s req_cycle: got %0d want %0d", tag, seen_req, t_req);
    end
    n_checks++;
    if (n_req !== 1) begin
      n_fail++;
      $display("FAIL %s req_pulses: got %0d want 1", tag, n_req);
    end
    n_checks++;
    if (seen_rdr !== t_x) begin
      n_fail++;
      $display("FAIL %s redirect_cycle: got %0d want %0d", tag, seen_rdr, t_x);
    end
    n_checks++;
    if (got_pc !== want_pc) begin
      n_fail++;
      $display("FAIL %s redirect_pc: got %h want %h", tag, got_pc, want_pc);
    end
    n_checks++;
    if (gate_err !== 0) begin
      n_fail++;
      $display("FAIL %s handshake_gating: %0d bad cycles want 0", tag, gate_err);
    end
    n_checks++;
    if (busy_err !== 0) begin
      n_fail++;
      $display("FAIL %s busy: %0d bad cycles want 0", tag, busy_err);
    end
    @(posedge clk);
    #1;
    exp_cnt = sat_inc(exp_cnt);
    n_checks++;
    if ({fence_busy, fence_cnt} !== {1'b0, CNT_W'(exp_cnt)}) begin
      n_fail++;
      $display("FAIL %s after_xfer busy/cnt: got %b/%0d want 0/%0d",
               tag, fence_busy, fence_cnt, exp_cnt);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_cnt = 0;
    n_checks++;
    if ({fsm_state, fence_busy, icache_flush_req, fence_redirect_valid,
         fence_redirect_pc, fence_cnt, fence_timeout} !==
        {FS_IDLE, 1'b0, 1'b0, 1'b0, 32'h0, CNT_W'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: st=%0d busy=%b req=%b rdr=%b pc=%h cnt=%0d tmo=%b want all 0",
               fsm_state, fence_busy, icache_flush_req, fence_redirect_valid,
               fence_redirect_pc, fence_cnt, fence_timeout);
    end
  endtask

  task automatic test_passthrough();
    logic v, r, f;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      f = v ? 1'b0 : 1'($urandom_range(0, 1));
      exe.exe_out_valid = v;
      exe.exe_in_ready  = r;
      exe.is_fence_i    = f;
      exe.pc_add_4      = $urandom();
      mem_store_pending = 1'($urandom_range(0, 1));
      icache_flush_done = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if ({exe.exe_in_valid, exe.exe_out_ready, fence_busy, icache_flush_req,
           fence_redirect_valid} !== {v, r, 3'b000}) begin
        n_fail++;
        $display("FAIL passthrough[%0d]: in_valid=%b out_ready=%b busy=%b req=%b rdr=%b want %b %b 0 0 0",
                 i, exe.exe_in_valid, exe.exe_out_ready, fence_busy,
                 icache_flush_req, fence_redirect_valid, v, r);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] pc;
    int seen_rdr;
    pc = 32'h8000_1234;
    seen_rdr = -1;
    // Fire at k=0, drain k=1, flush k=2, wait from k=3; done rises at k=26.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      drive_fence(pc);
      mem_store_pending = 1'b0;
      icache_flush_done = (k >= 26);
      exe.exe_in_ready  = (k >= 27);
      #1;
      if (k == 17) begin
        n_checks++;
        if (fence_timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_early: got %b want 0 after 14 wait cycles", fence_timeout);
        end
      end
      if (k == 18) begin
        n_checks++;
        if (fence_timeout !== 1'b1) begin
          n_fail++;
          $display("FAIL timeout_set: got %b want 1 after 15 wait cycles", fence_timeout);
        end
      end
      if (k == 25) begin
        n_checks++;
        if ({fsm_state, fence_timeout} !== {FS_WAIT, 1'b1}) begin
          n_fail++;
          $display("FAIL timeout_hold: state=%0d tmo=%b want %0d 1", fsm_state, fence_timeout, FS_WAIT);
        end
      end
      if (fence_redirect_valid === 1'b1) begin
        seen_rdr = k;
        break;
      end
    end
    n_checks++;
    if ({seen_rdr, fence_redirect_pc, fence_timeout} !== {27, pc, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_release: rdr_cycle=%0d pc=%h tmo=%b want 27 %h 1",
               seen_rdr, fence_redirect_pc, fence_timeout, pc);
    end
    @(posedge clk);
    #1;
    exp_cnt = sat_inc(exp_cnt);
    n_checks++;
    if (fence_cnt !== CNT_W'(exp_cnt)) begin
      n_fail++;
      $display("FAIL timeout_cnt: got %0d want %0d", fence_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int bad_pulse;
    bad_pulse = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive_fence(32'h8000_0abc);
      mem_store_pending = 1'b0;
      icache_flush_done = 1'b0;
      exe.exe_in_ready  = 1'b1;
      reset = (k == 5);
      #1;
      if (k == 4) begin
        n_checks++;
        if (fsm_state !== FS_WAIT) begin
          n_fail++;
          $display("FAIL reset_mid_pre: state=%0d want %0d", fsm_state, FS_WAIT);
        end
      end
      if (fence_redirect_valid === 1'b1) bad_pulse++;
    end
    @(negedge clk);
    reset = 1'b0;
    exe.exe_out_valid = 1'b0;
    exe.is_fence_i    = 1'b0;
    exe.exe_in_ready  = 1'b0;
    #1;
    exp_cnt = 0;
    n_checks++;
    if ({bad_pulse == 0, fsm_state, fence_busy, icache_flush_req,
         fence_redirect_valid, exe.exe_in_valid, exe.exe_out_ready,
         fence_redirect_pc, fence_cnt, fence_timeout} !==
        {1'b1, FS_IDLE, 5'b00000, 32'h0, CNT_W'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: pulses=%0d st=%0d busy=%b req=%b rdr=%b iv=%b or=%b pc=%h cnt=%0d tmo=%b want all 0",
               bad_pulse, fsm_state, fence_busy, icache_flush_req, fence_redirect_valid,
               exe.exe_in_valid, exe.exe_out_ready, fence_redirect_pc, fence_cnt, fence_timeout);
    end
    run_fence(32'h8000_0200, 1, 2, 1, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 10; i++) begin
      r = $urandom();
      if ($urandom_range(0, 1) == 1) drive_idle();
      run_fence(r & ~32'h3, $urandom_range(0, 6), $urandom_range(1, 10),
                $urandom_range(0, 4), "random");
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    exe.exe_out_valid = 1'b0;
    exe.is_fence_i    = 1'b0;
    exe.pc_add_4      = '0;
    exe.exe_in_ready  = 1'b0;
    mem_store_pending = 1'b0;
    icache_flush_done = 1'b0;

    test_reset();
    test_passthrough();
    run_fence(32'h8000_0010, 0, 3, 0, "basic");
    run_fence(32'h8000_0020, 5, 2, 0, "store_drain");
    run_fence(32'h8000_0030, 0, 1, 3, "release_stall");
    run_fence(32'h8000_0040, 0, 2, 0, "back_to_back_a");
    run_fence(32'h8000_0044, 2, 1, 1, "back_to_back_b");
    drive_idle();
    test_timeout();
    drive_idle();
    test_reset_mid();
    test_random();
    drive_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
